ahb_lite_master: RTL and testbench
==================================

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0011, the constant value driven on HPROT.
REQ-002 SHALL have parameter HMASTLOCK_VAL, default 1'b0, the constant value driven on HMASTLOCK.
REQ-003 SHALL have the following ports:
- HCLK  in  1  the single clock; everything is clocked on its rising edge.
- HRESETn  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_size  in  3  0 = byte, 1 = halfword, 2 = word.
- cmd_wdata  in  32  write data, right-justified.
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
- rsp_rdata  out  32  read data, right-justified and zero-extended.
- rsp_err  out  1  the transfer failed or was cancelled.
- HADDR  out  32.  HBURST  out  3.  HMASTLOCK  out  1.  HPROT  out  4.
- HSIZE  out  3.  HTRANS  out  2.  HWRITE  out  1.  HWDATA  out  32.
- HRDATA  in  32.  HREADY  in  1.  HRESP  in  1.

Function
REQ-004 SHALL issue only single transfers: HBURST=3'b000; HTRANS is NONSEQ (2'b10) or IDLE (2'b00), never BUSY or SEQ.
REQ-005 SHALL hold two stages:
- A: address phase; drives HADDR, HWRITE, HSIZE and HTRANS=NONSEQ while valid, HTRANS=IDLE when empty.
- D: data phase; drives HWDATA for write transfers.
REQ-006 SHALL drive all AHB outputs from registers; an accepted command appears on the bus in the cycle after acceptance.
REQ-007 SHALL compute cmd_ready = (!A.valid || HREADY) && !cancel_pend && !(D.valid && HRESP) && (legal(cmd) || (!A.valid && !D.valid)).
REQ-008 SHALL advance on each edge with HREADY=1: D <= A (or empty), then A <= the accepted command (or empty); with HREADY=0, A and D hold all values.
REQ-009 SHALL allow pipelining: back-to-back commands produce contiguous NONSEQ cycles, with address phase N+1 overlapping data phase N.
REQ-010 SHALL replicate write data onto HWDATA:
- size 0: cmd_wdata[7:0] on all four byte lanes.
- size 1: cmd_wdata[15:0] on both halfword lanes.
- size 2: cmd_wdata unchanged.
REQ-011 SHALL extract read data little-endian: byte lane HADDR[1:0], halfword lane HADDR[1], then zero-extend.
REQ-012 SHALL raise rsp_valid for exactly one cycle following each edge where D.valid && HREADY; rsp_rdata is the extracted HRDATA sampled at that edge and rsp_err = HRESP sampled at that edge.
REQ-013 SHALL return responses in acceptance order, exactly one response per accepted command.
REQ-014 SHALL treat a command as legal only when cmd_size<=2 and the address is aligned (size 1: addr[0]=0; size 2: addr[1:0]=0).
REQ-015 SHALL handle an illegal command as follows:
- It is accepted only when A and D are empty.
- It never appears on the bus.
- It yields rsp_valid=1, rsp_err=1, rsp_rdata=0 in the cycle after acceptance.
REQ-016 SHALL handle an AHB error as follows:
- On the edge ending the first error cycle (D.valid, HRESP=1, HREADY=0): clear A (HTRANS=IDLE next cycle) and set cancel_pend if A was valid.
- The errored transfer responds after the second error cycle, with rsp_err=1.
REQ-017 SHALL, when cancel_pend is set, emit rsp_valid=1, rsp_err=1, rsp_rdata=0 in the cycle after the errored response, then clear cancel_pend; cmd_ready stays 0 while cancel_pend is set.
REQ-018 SHALL sample HRDATA only for read transfers; for writes, rsp_rdata=0.

Reset
REQ-019 SHALL, while HRESETn=0, immediately force:
- HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
- A, D and cancel_pend empty/cleared.
REQ-020 SHALL discard any in-flight transfer when reset is asserted mid-transfer; no response is ever produced for it.
REQ-021 SHALL keep cmd_ready=0 while HRESETn=0 and accept commands from the first edge after deassertion.

Verification
REQ-022 Zero-wait word read: read 0xBF800008, HRDATA=0x1234ABCD -> NONSEQ for 1 cycle, then rsp_valid=1 two cycles after acceptance with rsp_rdata=0x1234ABCD, rsp_err=0.
REQ-023 Pipelined writes with a wait state:
- Stimulus: write byte 0xA5 to 0xBF700001, then write word 0xDEADBEEF to 0xBF700004, with HREADY=0 for 2 cycles during the first data phase.
- Response: HWDATA=0xA5A5A5A5, then 0xDEADBEEF; HADDR holds 0xBF700004 through the stall; two responses, both rsp_err=0.
REQ-024 Halfword read lane: read halfword at 0x80000002, HRDATA=0xBEEF1234 -> rsp_rdata=0x0000BEEF.
REQ-025 Error with a pending address phase:
- Stimulus: read 0x80000000 then read 0x80000004; on the first read's data phase, HRESP=1/HREADY=0 then HRESP=1/HREADY=1.
- Response: HTRANS=IDLE in the cycle after the first error cycle; two consecutive responses, both rsp_err=1; cmd_ready returns to 1 afterwards.
REQ-026 Illegal command plus reset:
- Stimulus: word write to 0x80000002.
- Response: no NONSEQ issued; rsp_err=1 one cycle after acceptance.
- Then: assert HRESETn=0 during a stalled transfer -> all outputs zero/IDLE at once; no response after release.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: a command/response front end driving a two-stage
// (address / data) pipeline. Responses return in acceptance order.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL     = 4'b0011,
    parameter logic       HMASTLOCK_VAL = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    // Address-phase stage
    logic        a_valid_q, a_valid_d;
    logic [31:0] a_addr_q, a_addr_d;
    logic        a_write_q, a_write_d;
    logic [2:0]  a_size_q, a_size_d;
    logic [31:0] a_wdata_q, a_wdata_d;

    // Data-phase stage
    logic        d_valid_q, d_valid_d;
    logic        d_write_q, d_write_d;
    logic [2:0]  d_size_q, d_size_d;
    logic [1:0]  d_lane_q, d_lane_d;
    logic [31:0] hwdata_q, hwdata_d;

    logic        cancel_q, cancel_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        cmd_legal;
    logic        accept;
    logic        err_first;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;

    always_comb begin
        cmd_legal = 1'b0;
        case (cmd_size)
            3'd0:    cmd_legal = 1'b1;
            3'd1:    cmd_legal = !cmd_addr[0];
            3'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
            default: cmd_legal = 1'b0;
        endcase
    end

    // Illegal commands are only taken when the pipeline is drained so their
    // response cannot overtake an earlier transfer.
    assign cmd_ready = HRESETn
                    && (!a_valid_q || HREADY)
                    && !cancel_q
                    && !(d_valid_q && HRESP)
                    && (cmd_legal || (!a_valid_q && !d_valid_q));

    assign accept    = cmd_valid && cmd_ready;
    assign err_first = d_valid_q && HRESP && !HREADY;

    always_comb begin
        wdata_rep = cmd_wdata;
        case (cmd_size)
            3'd0:    wdata_rep = {4{cmd_wdata[7:0]}};
            3'd1:    wdata_rep = {2{cmd_wdata[15:0]}};
            default: wdata_rep = cmd_wdata;
        endcase
    end

    always_comb begin
        rdata_ext = HRDATA;
        case (d_size_q)
            3'd0:    rdata_ext = {24'b0, HRDATA[{d_lane_q, 3'b000} +: 8]};
            3'd1:    rdata_ext = d_lane_q[1] ? {16'b0, HRDATA[31:16]} : {16'b0, HRDATA[15:0]};
            default: rdata_ext = HRDATA;
        endcase
    end

    always_comb begin
        a_valid_d   = a_valid_q;
        a_addr_d    = a_addr_q;
        a_write_d   = a_write_q;
        a_size_d    = a_size_q;
        a_wdata_d   = a_wdata_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        d_size_d    = d_size_q;
        d_lane_d    = d_lane_q;
        hwdata_d    = hwdata_q;
        cancel_d    = cancel_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'b0;
        rsp_err_d   = 1'b0;

        if (HREADY) begin
            d_valid_d = a_valid_q;
            d_write_d = a_write_q;
            d_size_d  = a_size_q;
            d_lane_d  = a_addr_q[1:0];
            hwdata_d  = a_wdata_q;
            a_valid_d = 1'b0;
        end

        if (accept && cmd_legal) begin
            a_valid_d = 1'b1;
            a_addr_d  = cmd_addr;
            a_write_d = cmd_write;
            a_size_d  = cmd_size;
            a_wdata_d = cmd_write ? wdata_rep : 32'b0;
        end

        // First cycle of a two-cycle error: withdraw the pending address phase
        // and remember that it still owes a response.
        if (err_first) begin
            a_valid_d = 1'b0;
            cancel_d  = cancel_q | a_valid_q;
        end

        if (d_valid_q && HREADY) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = HRESP;
            rsp_rdata_d = d_write_q ? 32'b0 : rdata_ext;
        end else if (accept && !cmd_legal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end else if (cancel_q && !d_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            cancel_d    = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid_q   <= 1'b0;
            a_addr_q    <= 32'b0;
            a_write_q   <= 1'b0;
            a_size_q    <= 3'b0;
            a_wdata_q   <= 32'b0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_size_q    <= 3'b0;
            d_lane_q    <= 2'b0;
            hwdata_q    <= 32'b0;
            cancel_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_addr_q    <= a_addr_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_size_q    <= d_size_d;
            d_lane_q    <= d_lane_d;
            hwdata_q    <= hwdata_d;
            cancel_q    <= cancel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign HADDR     = a_addr_q;
    assign HWRITE    = a_write_q;
    assign HSIZE     = a_size_q;
    assign HTRANS    = a_valid_q ? TransNonseq : TransIdle;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = HMASTLOCK_VAL;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master; bus responses are driven by hand and
// expected responses are tracked in an in-order scoreboard.
module tb_ahb_lite_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_lite_master dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HADDR     (HADDR),
        .HBURST    (HBURST),
        .HMASTLOCK (HMASTLOCK),
        .HPROT     (HPROT),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_size  = size;
        cmd_wdata = wdata;
        #1;
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic err);
        rsp_t r;
        r.rdata = rdata;
        r.err   = err;
        sb.push_back(r);
    endtask

    // Response monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge HCLK) begin
        if (rsp_valid === 1'b1) begin
            check("rsp_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        HRESETn   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'hBF800008;
        cmd_size  = 3'd2;
        cmd_wdata = 32'b0;
        HRDATA    = 32'b0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_htrans", {30'b0, HTRANS}, 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("hburst", {29'b0, HBURST}, 32'd0);
        check("hprot", {28'b0, HPROT}, 32'h3);
        check("hmastlock", {31'b0, HMASTLOCK}, 32'd0);
        HRESETn = 1'b1;

        // Zero-wait word read
        drive_cmd(1'b0, 32'hBF800008, 3'd2, 32'b0);
        check("t1_ready", {31'b0, cmd_ready}, 32'd1);
        expect_rsp(32'h1234ABCD, 1'b0);
        tick();
        cmd_valid = 1'b0;
        check("t1_htrans", {30'b0, HTRANS}, 32'h2);
        check("t1_haddr", HADDR, 32'hBF800008);
        check("t1_hwrite", {31'b0, HWRITE}, 32'd0);
        check("t1_hsize", {29'b0, HSIZE}, 32'd2);
        HRDATA = 32'h1234ABCD;
        tick();
        check("t1_htrans_idle", {30'b0, HTRANS}, 32'd0);
        check("t1_rsp_early", {31'b0, rsp_valid}, 32'd0);
        tick();
        check("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        tick();
        check("t1_rsp_pulse", {31'b0, rsp_valid}, 32'd0);

        // Pipelined writes with a two-cycle stall on the first data phase
        drive_cmd(1'b1, 32'hBF700001, 3'd0, 32'h000000A5);
        expect_rsp(32'd0, 1'b0);
        tick();
        drive_cmd(1'b1, 32'hBF700004, 3'd2, 32'hDEADBEEF);
        expect_rsp(32'd0, 1'b0);
        check("t2_htrans1", {30'b0, HTRANS}, 32'h2);
        check("t2_haddr1", HADDR, 32'hBF700001);
        check("t2_hwrite1", {31'b0, HWRITE}, 32'd1);
        check("t2_hsize1", {29'b0, HSIZE}, 32'd0);
        check("t2_ready_pipe", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        HREADY    = 1'b0;
        #1;
        check("t2_ready_stall", {31'b0, cmd_ready}, 32'd0);
        check("t2_htrans2", {30'b0, HTRANS}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            check("t2_haddr_hold", HADDR, 32'hBF700004);
            check("t2_hwdata1", HWDATA, 32'hA5A5A5A5);
            check("t2_no_rsp", {31'b0, rsp_valid}, 32'd0);
            if (i < 2) tick();
        end
        HREADY = 1'b1;
        tick();
        check("t2_rsp1", {31'b0, rsp_valid}, 32'd1);
        check("t2_hwdata2", HWDATA, 32'hDEADBEEF);
        check("t2_htrans_idle", {30'b0, HTRANS}, 32'd0);
        tick();
        check("t2_rsp2", {31'b0, rsp_valid}, 32'd1);
        tick();
        check("t2_rsp_done", {31'b0, rsp_valid}, 32'd0);

        // Halfword read from the upper lane
        drive_cmd(1'b0, 32'h80000002, 3'd1, 32'b0);
        expect_rsp(32'h0000BEEF, 1'b0);
        tick();
        cmd_valid = 1'b0;
        check("t3_hsize", {29'b0, HSIZE}, 32'd1);
        HRDATA = 32'hBEEF1234;
        tick();
        tick();
        check("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        tick();

        // Error response with a pending address phase behind it
        HRDATA = 32'b0;
        drive_cmd(1'b0, 32'h80000000, 3'd2, 32'b0);
        expect_rsp(32'd0, 1'b1);
        tick();
        drive_cmd(1'b0, 32'h80000004, 3'd2, 32'b0);
        expect_rsp(32'd0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        HRESP     = 1'b1;
        HREADY    = 1'b0;
        #1;
        check("t4_htrans_pend", {30'b0, HTRANS}, 32'h2);
        check("t4_ready_err1", {31'b0, cmd_ready}, 32'd0);
        tick();
        check("t4_htrans_cancel", {30'b0, HTRANS}, 32'd0);
        HREADY = 1'b1;
        #1;
        check("t4_ready_err2", {31'b0, cmd_ready}, 32'd0);
        tick();
        check("t4_rsp_err_valid", {31'b0, rsp_valid}, 32'd1);
        check("t4_rsp_err", {31'b0, rsp_err}, 32'd1);
        HRESP = 1'b0;
        #1;
        check("t4_ready_cancel", {31'b0, cmd_ready}, 32'd0);
        tick();
        check("t4_cancel_valid", {31'b0, rsp_valid}, 32'd1);
        check("t4_cancel_err", {31'b0, rsp_err}, 32'd1);
        check("t4_ready_back", {31'b0, cmd_ready}, 32'd1);
        tick();
        check("t4_rsp_done", {31'b0, rsp_valid}, 32'd0);

        // Byte read, then an illegal command held until the pipeline drains
        HRDATA = 32'h55AA33CC;
        drive_cmd(1'b0, 32'h80000013, 3'd0, 32'b0);
        expect_rsp(32'h00000055, 1'b0);
        tick();
        drive_cmd(1'b1, 32'h80000002, 3'd2, 32'h11111111);
        check("t5_ready_a_busy", {31'b0, cmd_ready}, 32'd0);
        tick();
        check("t5_ready_d_busy", {31'b0, cmd_ready}, 32'd0);
        tick();
        check("t5_byte_rsp", {31'b0, rsp_valid}, 32'd1);
        check("t5_ready_drained", {31'b0, cmd_ready}, 32'd1);
        expect_rsp(32'd0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("t5_ill_rsp", {31'b0, rsp_valid}, 32'd1);
        check("t5_ill_err", {31'b0, rsp_err}, 32'd1);
        check("t5_ill_no_bus", {30'b0, HTRANS}, 32'd0);
        tick();
        check("t5_ill_no_bus2", {30'b0, HTRANS}, 32'd0);
        check("t5_ill_pulse", {31'b0, rsp_valid}, 32'd0);

        // Reset during a stalled write: no response must ever appear for it
        drive_cmd(1'b1, 32'h80000020, 3'd2, 32'h12345678);
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        check("t6_hwdata_live", HWDATA, 32'h12345678);
        tick();
        #2;
        HRESETn = 1'b0;
        #1;
        check("t6_rst_htrans", {30'b0, HTRANS}, 32'd0);
        check("t6_rst_haddr", HADDR, 32'd0);
        check("t6_rst_hwdata", HWDATA, 32'd0);
        check("t6_rst_hwrite", {31'b0, HWRITE}, 32'd0);
        check("t6_rst_hsize", {29'b0, HSIZE}, 32'd0);
        check("t6_rst_rsp", {31'b0, rsp_valid}, 32'd0);
        check("t6_rst_ready", {31'b0, cmd_ready}, 32'd0);
        HREADY = 1'b1;
        tick();
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
